// File: rtl/alu_pkg.sv
// Shared ALU-side definitions: datapath defaults, arbiter FSM encoding and
// the function codes understood by the external ALU.
package alu_pkg;

  localparam int ALU_WIDTH = 32;
  localparam int ALU_OPW   = 6;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  localparam logic [5:0] OP_ADD = 6'h20;
  localparam logic [5:0] OP_SUB = 6'h22;
  localparam logic [5:0] OP_AND = 6'h24;
  localparam logic [5:0] OP_OR  = 6'h25;
  localparam logic [5:0] OP_SLT = 6'h2A;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant: a lone requester always wins, and on contention
// the requester that was not granted last time wins.
module rr_arb2 (
  input  logic       valid0_i,
  input  logic       valid1_i,
  input  logic       last_grant_i,
  output logic [1:0] grant_o
);

  // One-hot grant selection
  always_comb begin
    grant_o = 2'b00;
    if (valid0_i && valid1_i) begin
      grant_o = last_grant_i ? 2'b01 : 2'b10;
    end else if (valid0_i) begin
      grant_o = 2'b01;
    end else if (valid1_i) begin
      grant_o = 2'b10;
    end else begin
      grant_o = 2'b00;
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one external combinational ALU between two requesters: accept one
// operation, hold its operands on the ALU for a cycle, then present the result.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH,
  parameter int OPW   = ALU_OPW
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [OPW-1:0]   req0_alucont,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [OPW-1:0]   req1_alucont,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic             resp_id,
  output logic [WIDTH-1:0] resp_result,
  output logic             resp_overflow,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [OPW-1:0]   alu_alucont,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_overflow,
  output logic             busy
);

  logic [1:0]       state_q, state_d;
  logic             last_grant_q, last_grant_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [OPW-1:0]   op_q, op_d;
  logic             id_q, id_d;
  logic [WIDTH-1:0] resp_result_q, resp_result_d;
  logic             resp_overflow_q, resp_overflow_d;
  logic             resp_valid_q, resp_valid_d;
  logic             busy_q, busy_d;
  logic [1:0]       grant_s;
  logic             idle_s;
  logic             accept_s;

  rr_arb2 u_rr_arb2 (
    .valid0_i     (req0_valid),
    .valid1_i     (req1_valid),
    .last_grant_i (last_grant_q),
    .grant_o      (grant_s)
  );

  assign idle_s     = (state_q == ST_IDLE);
  assign accept_s   = idle_s && (grant_s != 2'b00);
  assign req0_ready = idle_s && grant_s[0];
  assign req1_ready = idle_s && grant_s[1];

  // Next-state, capture and response logic
  always_comb begin
    state_d         = state_q;
    last_grant_d    = last_grant_q;
    a_d             = a_q;
    b_d             = b_q;
    op_d            = op_q;
    id_d            = id_q;
    resp_result_d   = resp_result_q;
    resp_overflow_d = resp_overflow_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          state_d      = ST_EXEC;
          id_d         = grant_s[1];
          last_grant_d = grant_s[1];
          a_d          = grant_s[1] ? req1_a       : req0_a;
          b_d          = grant_s[1] ? req1_b       : req0_b;
          op_d         = grant_s[1] ? req1_alucont : req0_alucont;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_EXEC: begin
        state_d         = ST_RESP;
        resp_result_d   = alu_result;
        resp_overflow_d = alu_overflow;
      end
      ST_RESP: begin
        if (resp_ready) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_RESP;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    resp_valid_d = (state_d == ST_RESP);
    busy_d       = (state_d != ST_IDLE);
  end

  // State and holding registers; last_grant resets to 1 so requester 0 wins first
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q         <= ST_IDLE;
      last_grant_q    <= 1'b1;
      a_q             <= '0;
      b_q             <= '0;
      op_q            <= '0;
      id_q            <= 1'b0;
      resp_result_q   <= '0;
      resp_overflow_q <= 1'b0;
      resp_valid_q    <= 1'b0;
      busy_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      last_grant_q    <= last_grant_d;
      a_q             <= a_d;
      b_q             <= b_d;
      op_q            <= op_d;
      id_q            <= id_d;
      resp_result_q   <= resp_result_d;
      resp_overflow_q <= resp_overflow_d;
      resp_valid_q    <= resp_valid_d;
      busy_q          <= busy_d;
    end
  end

  assign alu_a         = a_q;
  assign alu_b         = b_q;
  assign alu_alucont   = op_q;
  assign resp_id       = id_q;
  assign resp_result   = resp_result_q;
  assign resp_overflow = resp_overflow_q;
  assign resp_valid    = resp_valid_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed scenarios, then randomized
// traffic scored against a transaction-level model of the arbiter.
module tb_alu_arbiter;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req0_valid, req1_valid, req0_ready, req1_ready;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic [5:0]  req0_alucont, req1_alucont;
  logic        resp_valid, resp_ready, resp_id, resp_overflow;
  logic [31:0] resp_result, alu_a, alu_b, alu_result;
  logic [5:0]  alu_alucont;
  logic        alu_overflow, busy;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  alu_arbiter dut (
    .clk(clk), .reset_n(reset_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a),
    .req0_b(req0_b), .req0_alucont(req0_alucont),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a),
    .req1_b(req1_b), .req1_alucont(req1_alucont),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
    .resp_result(resp_result), .resp_overflow(resp_overflow),
    .alu_a(alu_a), .alu_b(alu_b), .alu_alucont(alu_alucont),
    .alu_result(alu_result), .alu_overflow(alu_overflow), .busy(busy)
  );

  // External ALU stand-in
  always_comb begin
    alu_result   = 32'd0;
    alu_overflow = 1'b0;
    case (alu_alucont)
      OP_ADD: begin
        alu_result   = alu_a + alu_b;
        alu_overflow = (alu_a[31] == alu_b[31]) && (alu_result[31] != alu_a[31]);
      end
      OP_SUB: begin
        alu_result   = alu_a - alu_b;
        alu_overflow = (alu_a[31] != alu_b[31]) && (alu_result[31] != alu_a[31]);
      end
      OP_AND:  alu_result = alu_a & alu_b;
      OP_OR:   alu_result = alu_a | alu_b;
      OP_SLT:  alu_result = {31'd0, ($signed(alu_a) < $signed(alu_b))};
      default: alu_result = 32'd0;
    endcase
  end

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference arithmetic done on wide signed integers
  function automatic void ref_alu(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output logic o);
    longint sa, sb, s;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    s  = 64'sd0;
    r  = 32'd0;
    o  = 1'b0;
    case (op)
      OP_ADD:  s = sa + sb;
      OP_SUB:  s = sa - sb;
      default: s = 64'sd0;
    endcase
    case (op)
      OP_ADD, OP_SUB: begin
        r = 32'(s);
        o = (s > 64'sh7FFFFFFF) || (s < -64'sh80000000);
      end
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_SLT:  r = (sa < sb) ? 32'd1 : 32'd0;
      default: r = 32'd0;
    endcase
  endfunction

  task automatic idle_inputs();
    req0_valid = 1'b0; req1_valid = 1'b0; resp_ready = 1'b0;
    req0_a = 32'd0; req0_b = 32'd0; req0_alucont = 6'd0;
    req1_a = 32'd0; req1_b = 32'd0; req1_alucont = 6'd0;
  endtask

  task automatic set_req(input int id, input logic [31:0] a, input logic [31:0] b, input logic [5:0] op);
    if (id == 0) begin
      req0_valid = 1'b1; req0_a = a; req0_b = b; req0_alucont = op;
    end else begin
      req1_valid = 1'b1; req1_a = a; req1_b = b; req1_alucont = op;
    end
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    idle_inputs();
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  typedef struct {
    logic        id;
    logic [31:0] a, b, res;
    logic [5:0]  op;
    logic        ovf;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        e;
  bit          hold[2];
  logic [31:0] ha[2], hb[2];
  logic [5:0]  hop[2];
  logic [5:0]  ops[5];
  int          n_seen;
  int          last_id, cnt, accepted, completed, cyc;
  bit          pending, consume, exp_rv;
  logic [1:0]  g;

  initial begin
    ops[0] = OP_ADD; ops[1] = OP_SUB; ops[2] = OP_AND; ops[3] = OP_OR; ops[4] = OP_SLT;
    idle_inputs();
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("rst_resp_valid", resp_valid, 1'b0);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_resp_result", resp_result, 32'd0);
    check_eq("rst_resp_ovf", resp_overflow, 1'b0);
    check_eq("rst_resp_id", resp_id, 1'b0);
    check_eq("rst_alu_a", alu_a, 32'd0);
    reset_n = 1'b1;

    // Single request: 5 + 3
    @(negedge clk);
    set_req(0, 32'd5, 32'd3, OP_ADD);
    #1 check_eq("single_ready0", req0_ready, 1'b1);
    check_eq("single_ready1", req1_ready, 1'b0);
    @(negedge clk);
    req0_valid = 1'b0;
    check_eq("single_exec_rv", resp_valid, 1'b0);
    check_eq("single_exec_busy", busy, 1'b1);
    @(negedge clk);
    check_eq("single_rv", resp_valid, 1'b1);
    check_eq("single_id", resp_id, 1'b0);
    check_eq("single_result", resp_result, 32'd8);
    check_eq("single_ovf", resp_overflow, 1'b0);
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    check_eq("single_done_rv", resp_valid, 1'b0);
    check_eq("single_done_busy", busy, 1'b0);

    // Contention after reset: alternation 0,1,0,1
    pulse_reset();
    @(negedge clk);
    set_req(0, 32'd1, 32'd2, OP_ADD);
    set_req(1, 32'd10, 32'd4, OP_SUB);
    resp_ready = 1'b1;
    #1 check_eq("cont_first_ready0", req0_ready, 1'b1);
    check_eq("cont_first_ready1", req1_ready, 1'b0);
    n_seen = 0;
    for (int i = 0; i < 40 && n_seen < 4; i++) begin
      @(negedge clk);
      if (resp_valid) begin
        check_eq("cont_id", resp_id, n_seen % 2);
        check_eq("cont_result", resp_result, (n_seen % 2) ? 32'd6 : 32'd3);
        n_seen++;
      end
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    check_eq("cont_count", n_seen, 4);
    @(negedge clk);
    resp_ready = 1'b0;

    // Signed overflow on add
    @(negedge clk);
    set_req(0, 32'h7FFFFFFF, 32'd1, OP_ADD);
    @(negedge clk);
    req0_valid = 1'b0;
    @(negedge clk);
    check_eq("ovf_rv", resp_valid, 1'b1);
    check_eq("ovf_result", resp_result, 32'h80000000);
    check_eq("ovf_flag", resp_overflow, 1'b1);
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;

    // Backpressure with both requesters waiting
    @(negedge clk);
    set_req(1, 32'd3, 32'd5, OP_SUB);
    @(negedge clk);
    req1_valid = 1'b0;
    @(negedge clk);
    set_req(0, 32'd100, 32'd1, OP_ADD);
    set_req(1, 32'hF0, 32'h3C, OP_AND);
    for (int i = 0; i < 5; i++) begin
      #1 check_eq("bp_ready0", req0_ready, 1'b0);
      check_eq("bp_ready1", req1_ready, 1'b0);
      check_eq("bp_rv", resp_valid, 1'b1);
      check_eq("bp_result", resp_result, 32'hFFFFFFFE);
      check_eq("bp_id", resp_id, 1'b1);
      check_eq("bp_ovf", resp_overflow, 1'b0);
      check_eq("bp_alu_a", alu_a, 32'd3);
      check_eq("bp_alu_b", alu_b, 32'd5);
      check_eq("bp_alu_op", alu_alucont, OP_SUB);
      @(negedge clk);
    end
    resp_ready = 1'b1;
    #1 check_eq("bp_release_ready0", req0_ready, 1'b0);
    check_eq("bp_release_ready1", req1_ready, 1'b0);
    @(negedge clk);
    resp_ready = 1'b0;
    check_eq("bp_idle_busy", busy, 1'b0);
    check_eq("bp_idle_rv", resp_valid, 1'b0);
    #1 check_eq("bp_next_ready0", req0_ready, 1'b1);
    check_eq("bp_next_ready1", req1_ready, 1'b0);
    @(negedge clk);
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(negedge clk);
    check_eq("bp_next_result", resp_result, 32'd101);
    check_eq("bp_next_id", resp_id, 1'b0);
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;

    // Reset while in EXEC discards the operation
    @(negedge clk);
    set_req(0, 32'd9, 32'd9, OP_ADD);
    @(negedge clk);
    req0_valid = 1'b0;
    check_eq("rexec_busy", busy, 1'b1);
    reset_n = 1'b0;
    #1 check_eq("rexec_rv", resp_valid, 1'b0);
    check_eq("rexec_busy0", busy, 1'b0);
    check_eq("rexec_result", resp_result, 32'd0);
    check_eq("rexec_alu_a", alu_a, 32'd0);
    check_eq("rexec_id", resp_id, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_eq("rexec_no_resp", resp_valid, 1'b0);
    end
    set_req(0, 32'd2, 32'd2, OP_ADD);
    set_req(1, 32'd7, 32'd7, OP_ADD);
    #1 check_eq("rexec_first_grant", req0_ready, 1'b1);
    @(negedge clk);
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(negedge clk);
    check_eq("rexec_after_result", resp_result, 32'd4);
    check_eq("rexec_after_id", resp_id, 1'b0);
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;

    // Randomized traffic against the transaction model
    pulse_reset();
    last_id = 1; pending = 1'b0; consume = 1'b0; cnt = 0;
    accepted = 0; completed = 0; cyc = 0;
    hold[0] = 1'b0; hold[1] = 1'b0;
    while (completed < 1000 && cyc < 40000) begin
      @(negedge clk);
      cyc++;
      if (consume) begin
        void'(exp_q.pop_front());
        pending = 1'b0; consume = 1'b0; completed++;
      end
      if (pending) cnt++;
      exp_rv = pending && (cnt >= 2);
      check_eq("rnd_resp_valid", resp_valid, exp_rv);
      check_eq("rnd_busy", busy, pending);
      if (pending) begin
        check_eq("rnd_alu_a", alu_a, exp_q[0].a);
        check_eq("rnd_alu_b", alu_b, exp_q[0].b);
        check_eq("rnd_alu_op", alu_alucont, exp_q[0].op);
      end
      if (exp_rv && resp_valid) begin
        check_eq("rnd_id", resp_id, exp_q[0].id);
        check_eq("rnd_result", resp_result, exp_q[0].res);
        check_eq("rnd_ovf", resp_overflow, exp_q[0].ovf);
      end
      resp_ready = ($urandom_range(0, 99) < 60);
      if (exp_rv && resp_ready) consume = 1'b1;
      for (int i = 0; i < 2; i++) begin
        if (accepted >= 1000) begin
          hold[i] = 1'b0;
        end else if (!hold[i]) begin
          if ($urandom_range(0, 99) < 50) begin
            hold[i] = 1'b1;
            hop[i] = ops[$urandom_range(0, 4)];
            ha[i] = ($urandom_range(0, 7) == 0) ? 32'h7FFFFFFF : $urandom;
            hb[i] = ($urandom_range(0, 7) == 0) ? 32'h80000000 : $urandom;
          end
        end else if ($urandom_range(0, 99) < 5) begin
          hold[i] = 1'b0;
        end
      end
      req0_valid = hold[0]; req0_a = ha[0]; req0_b = hb[0]; req0_alucont = hop[0];
      req1_valid = hold[1]; req1_a = ha[1]; req1_b = hb[1]; req1_alucont = hop[1];
      #1;
      g = 2'b00;
      if (!pending) begin
        if (hold[0] && hold[1]) g = (last_id == 1) ? 2'b01 : 2'b10;
        else if (hold[0]) g = 2'b01;
        else if (hold[1]) g = 2'b10;
      end
      check_eq("rnd_ready0", req0_ready, g[0]);
      check_eq("rnd_ready1", req1_ready, g[1]);
      if (g != 2'b00) begin
        e.id = g[1];
        e.a  = ha[g[1]];
        e.b  = hb[g[1]];
        e.op = hop[g[1]];
        ref_alu(e.op, e.a, e.b, e.res, e.ovf);
        exp_q.push_back(e);
        pending = 1'b1; cnt = 0;
        last_id = g[1] ? 1 : 0;
        hold[g[1]] = 1'b0;
        accepted++;
      end
    end
    check_eq("rnd_completed", completed, 1000);
    check_eq("rnd_accepted", accepted, 1000);
    check_eq("rnd_queue_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
